// File: rtl/byte_mem_responder_pkg.sv
// Shared types and default sizes for the byte memory responder.
// MEM_RESPONDER_RR_ARB_EN (defined elsewhere) switches the arbiter to round-robin.
package byte_mem_responder_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LATENCY    = 2;
  localparam int DATA_WIDTH     = 8;
  localparam int ADDR_BUS_WIDTH = 32;
  // Wide enough for LATENCY up to 15.
  localparam int CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [1:0] GRANT_A = 2'b01;
  localparam logic [1:0] GRANT_B = 2'b10;

endpackage

// File: rtl/byte_mem_responder_arbiter.sv
// Grant selection between the two pending ports of the byte memory responder.
// With MEM_RESPONDER_RR_ARB_EN defined, contested grants alternate; otherwise port A wins.
module mem_responder_arbiter
  import byte_mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       arb_en,
  input  logic       pendA,
  input  logic       pendB,
  input  logic       done,
  output logic [1:0] grant
);

  logic prefer_b;

`ifdef MEM_RESPONDER_RR_ARB_EN
  logic prefer_b_q;
  logic served_b_q;
  logic contested_q;

  // Only a grant made while both ports were waiting moves the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prefer_b_q  <= 1'b0;
      served_b_q  <= 1'b0;
      contested_q <= 1'b0;
    end else begin
      if (grant != 2'b00) begin
        served_b_q  <= grant[1];
        contested_q <= pendA && pendB;
      end
      if (done && contested_q) begin
        prefer_b_q <= !served_b_q;
      end
    end
  end

  assign prefer_b = prefer_b_q;
`else
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{clk, reset, done};
  assign prefer_b = 1'b0;
`endif

  always_comb begin
    grant = 2'b00;
    if (arb_en) begin
      if (pendB && (!pendA || prefer_b)) begin
        grant = GRANT_B;
      end else if (pendA) begin
        grant = GRANT_A;
      end
    end
  end

endmodule

// File: rtl/byte_mem_responder.sv
// Two-port (A read/write, B read-only) byte memory served one transaction at a time.
// Arbitration mode is selected by MEM_RESPONDER_RR_ARB_EN inside mem_responder_arbiter.
module byte_mem_responder
  import byte_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LATENCY    = DEF_LATENCY,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_BUS_WIDTH-1:0] addrA,
  input  logic [ADDR_BUS_WIDTH-1:0] addrB,
  input  logic                      writeEnable,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  input  logic                      requestA,
  input  logic                      requestB,
  output logic [DATA_WIDTH-1:0]     outA,
  output logic [DATA_WIDTH-1:0]     outB,
  output logic                      busyA,
  output logic                      busyB
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LATENCY - 1);

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    served_b_q;
  logic                    busy_a_q, busy_b_q;
  logic                    pend_a_q, pend_b_q;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_b_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [DATA_WIDTH-1:0]   out_a_q, out_b_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    acc_a, acc_b;
  logic                    pend_a, pend_b;
  logic [1:0]              grant;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic                    mem_wr;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{addrA[ADDR_BUS_WIDTH-1:ADDR_WIDTH], addrB[ADDR_BUS_WIDTH-1:ADDR_WIDTH]};

  assign acc_a = requestA && !busy_a_q;
  assign acc_b = requestB && !busy_b_q;
  // A request accepted this edge may be granted on the same edge.
  assign pend_a = pend_a_q || acc_a;
  assign pend_b = pend_b_q || acc_b;

  assign acc_addr = served_b_q ? addr_b_q : addr_a_q;
  assign mem_wr   = (state_q == DONE) && !served_b_q && we_q;

  mem_responder_arbiter u_arbiter (
    .clk    (clk),
    .reset  (reset),
    .arb_en (state_q == IDLE),
    .pendA  (pend_a),
    .pendB  (pend_b),
    .done   (state_q == DONE),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      served_b_q <= 1'b0;
      busy_a_q   <= 1'b0;
      busy_b_q   <= 1'b0;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
    end else begin
      if (acc_a) begin
        busy_a_q <= 1'b1;
        pend_a_q <= 1'b1;
        addr_a_q <= addrA[ADDR_WIDTH-1:0];
        we_q     <= writeEnable;
        din_q    <= dataIn;
      end
      if (acc_b) begin
        busy_b_q <= 1'b1;
        pend_b_q <= 1'b1;
        addr_b_q <= addrB[ADDR_WIDTH-1:0];
      end

      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            state_q    <= ACCESS;
            cnt_q      <= '0;
            served_b_q <= grant[1];
            if (grant[1]) pend_b_q <= 1'b0;
            else          pend_a_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) state_q <= DONE;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          if (served_b_q) begin
            busy_b_q <= 1'b0;
            out_b_q  <= rd_data_q;
          end else begin
            busy_a_q <= 1'b0;
            out_a_q  <= we_q ? din_q : rd_data_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered read; the address is stable for the whole ACCESS phase.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[acc_addr];
  end

  generate
    if (INIT_ZERO) begin : g_init_zero
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_wr) begin
          mem_q[acc_addr] <= din_q;
        end
      end
    end else begin : g_no_init
      always_ff @(posedge clk) begin
        if (mem_wr) mem_q[acc_addr] <= din_q;
      end
    end
  endgenerate

  assign outA  = out_a_q;
  assign outB  = out_b_q;
  assign busyA = busy_a_q;
  assign busyB = busy_b_q;

endmodule

// File: tb/tb_byte_mem_responder.sv
// Scoreboard bench for byte_mem_responder (defaults: ADDR_WIDTH=10, LATENCY=2, INIT_ZERO=1).
module tb_byte_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addrA = '0;
  logic [31:0] addrB = '0;
  logic        writeEnable = 1'b0;
  logic [7:0]  dataIn = '0;
  logic        requestA = 1'b0;
  logic        requestB = 1'b0;
  logic [7:0]  outA, outB;
  logic        busyA, busyB;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  always #5 clk = ~clk;

  byte_mem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .addrA       (addrA),
    .addrB       (addrB),
    .writeEnable (writeEnable),
    .dataIn      (dataIn),
    .requestA    (requestA),
    .requestB    (requestB),
    .outA        (outA),
    .outB        (outB),
    .busyA       (busyA),
    .busyB       (busyB)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a falling busy marks a completed transaction; compare against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_a && !busyA) begin
        if (exp_a.size() == 0) check("unexpected_doneA", 32'(outA), 32'hFFFF_FFFF);
        else begin
          $display("txn port A out=0x%02h", outA);
          check("outA", 32'(outA), 32'(exp_a.pop_front()));
        end
      end
      if (prev_b && !busyB) begin
        if (exp_b.size() == 0) check("unexpected_doneB", 32'(outB), 32'hFFFF_FFFF);
        else begin
          $display("txn port B out=0x%02h", outB);
          check("outB", 32'(outB), 32'(exp_b.pop_front()));
        end
      end
    end
    prev_a = busyA;
    prev_b = busyB;
  end

  task automatic wait_ready(input bit wa, input bit wb);
    int t;
    t = 0;
    @(negedge clk);
    while ((wa && busyA) || (wb && busyB)) begin
      t++;
      if (t > 200) begin
        check("wait_ready_timeout", 32'(t), 32'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [7:0] data,
                         input bit push, input logic [7:0] expv);
    wait_ready(1'b1, 1'b0);
    addrA = addr; writeEnable = we; dataIn = data; requestA = 1'b1;
    if (push) exp_a.push_back(expv);
    @(posedge clk); #1;
    requestA = 1'b0; addrA = ~addr; dataIn = ~data; writeEnable = ~we;
  endtask

  task automatic issue_b(input logic [31:0] addr, input logic [7:0] expv);
    wait_ready(1'b0, 1'b1);
    addrB = addr; requestB = 1'b1;
    exp_b.push_back(expv);
    @(posedge clk); #1;
    requestB = 1'b0; addrB = ~addr;
  endtask

  task automatic collide(input string name, input logic exp_first_a);
    int t;
    logic first_a;
    wait_ready(1'b1, 1'b1);
    addrA = 32'h10; writeEnable = 1'b0; addrB = 32'h07;
    requestA = 1'b1; requestB = 1'b1;
    exp_a.push_back(8'hA5);
    exp_b.push_back(8'h3C);
    @(posedge clk); #1;
    requestA = 1'b0; requestB = 1'b0;
    t = 0;
    while (busyA && busyB && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    first_a = !busyA;
    check(name, 32'(first_a), 32'(exp_first_a));
    wait_ready(1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [11:0] pat;

    #1 reset = 1'b1;
    #1;
    check("reset_outA", 32'(outA), 32'd0);
    check("reset_outB", 32'(outB), 32'd0);
    check("reset_busyA", 32'(busyA), 32'd0);
    check("reset_busyB", 32'(busyB), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Preload 0xA5 at 0x10, then read it back through B and time busyB.
    issue_a(1'b1, 32'h10, 8'hA5, 1'b1, 8'hA5);
    wait_ready(1'b1, 1'b1);
    addrB = 32'h10; requestB = 1'b1;
    exp_b.push_back(8'hA5);
    @(posedge clk); #1;
    requestB = 1'b0; addrB = 32'h3FF;
    check("busyB_rise", 32'(busyB), 32'd1);
    cyc = 0;
    while (busyB && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busyB_cycles", 32'(cyc), 32'd3);

    // Write then read the same address on A.
    issue_a(1'b1, 32'h7, 8'h3C, 1'b1, 8'h3C);
    issue_a(1'b0, 32'h7, 8'h00, 1'b1, 8'h3C);
    wait_ready(1'b1, 1'b1);

    // Address wrap on both ports; A is accepted while B is served.
    issue_b(32'h0000_0407, 8'h3C);
    issue_a(1'b1, 32'h0000_0C11, 8'h5A, 1'b1, 8'h5A);
    wait_ready(1'b1, 1'b1);
    issue_b(32'h11, 8'h5A);
    wait_ready(1'b1, 1'b1);

    collide("collision1_first_A", 1'b1);
`ifdef MEM_RESPONDER_RR_ARB_EN
    collide("collision2_first_A", 1'b0);
`else
    collide("collision2_first_A", 1'b1);
`endif

    // Reset during the ACCESS phase of a write.
    wait_ready(1'b1, 1'b1);
    issue_a(1'b1, 32'h20, 8'hFF, 1'b0, 8'h00);
    #2 reset = 1'b1;
    #1;
    check("abort_busyA", 32'(busyA), 32'd0);
    check("abort_outA", 32'(outA), 32'd0);
    requestA = 1'b1; addrA = 32'h20; writeEnable = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("busyA_in_reset", 32'(busyA), 32'd0);
    end
    @(negedge clk);
    requestA = 1'b0;
    reset = 1'b0;
    issue_a(1'b0, 32'h20, 8'h00, 1'b1, 8'h00);
    issue_b(32'h10, 8'h00);
    wait_ready(1'b1, 1'b1);

    // Held request on B for 10 edges: three back-to-back reads.
    issue_a(1'b1, 32'h30, 8'h77, 1'b1, 8'h77);
    wait_ready(1'b1, 1'b1);
    addrB = 32'h30; requestB = 1'b1;
    repeat (3) exp_b.push_back(8'h77);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      pat[i] = busyB;
      if (i == 9) requestB = 1'b0;
    end
    check("held_busyB_pattern", 32'(pat), 32'h777);
    wait_ready(1'b1, 1'b1);
    repeat (3) @(negedge clk);

    check("expA_drained", 32'(exp_a.size()), 32'd0);
    check("expB_drained", 32'(exp_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
